apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one APB master port (to timer_top register file) among
//  NUM_REQ on-chip requesters (e.g. CPU shim, DMA config engine, test sequencer). Accepts simple
//  valid/ready register requests, runs IDLE->SETUP->ACCESS APB transfers, returns read data and
//  status per requester. Guarantees one idle cycle (psel=0) between transfers; bounds pready waits.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  AW           8   APB address width
//  DW           8   APB data width
//  TIMEOUT_CYC  16  max ACCESS cycles with pready=0 before abort; 0 disables timeout
// PORTS
//  pclk        in   1          APB clock; all logic on posedge
//  presetn     in   1          synchronous active-low reset
//  req_valid   in   NUM_REQ    request pending, held until accepted
//  req_write   in   NUM_REQ    1=write, 0=read
//  req_addr    in   NUM_REQ*AW per-requester address, slice i = req i
//  req_wdata   in   NUM_REQ*DW per-requester write data
//  req_ready   out  NUM_REQ    one-hot accept strobe (combinational, IDLE only)
//  rsp_valid   out  NUM_REQ    one-hot completion strobe, 1 cycle
//  rsp_rdata   out  DW         read data (0 for writes and timeouts)
//  rsp_err     out  1          1 = transfer aborted by timeout; qualified by rsp_valid
//  psel/penable/pwrite out 1   APB control
//  paddr       out  AW         APB address
//  pwdata      out  DW         APB write data
//  prdata      in   DW         APB read data
//  pready      in   1          APB ready
// BEHAVIOUR
//  Reset (presetn=0 at posedge): state=IDLE, psel/penable/pwrite=0, paddr/pwdata=0, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0, timeout cnt=0, rr priority pointer=0. Reset mid-transfer drops
//   psel/penable at that edge; in-flight request discarded, no rsp_valid issued.
//  FSM: IDLE -> SETUP -> ACCESS -> IDLE. No direct ACCESS->SETUP path.
//   IDLE: if any req_valid, winner = first set bit scanning from ptr upward (wrap at NUM_REQ-1);
//    req_ready[winner]=1 this cycle; at edge latch write/addr/wdata/id, psel=1, penable=0 -> SETUP.
//    Pointer <- winner+1 (mod NUM_REQ). No req_valid: stay, pointer unchanged.
//   SETUP: exactly 1 cycle; at edge penable=1 -> ACCESS. paddr/pwdata/pwrite stable SETUP..ACCESS.
//   ACCESS: pready=1 -> at edge psel=penable=0, rsp_valid[id]=1, rsp_rdata=prdata if read else 0,
//    rsp_err=0 -> IDLE. pready=0 -> cnt++; if TIMEOUT_CYC!=0 and cnt reaches TIMEOUT_CYC-1 with
//    pready still 0: abort, psel=penable=0, rsp_valid[id]=1, rsp_err=1, rsp_rdata=0 -> IDLE.
//    cnt cleared on entry to ACCESS.
//  Latency: accept at cycle T -> SETUP T+1 -> ACCESS T+2 -> rsp_valid T+3 (zero-wait slave).
//   The T+3 IDLE cycle may grant the next request: max 1 transfer per 3 cycles, psel low >=1 cycle.
//  req_ready never asserted outside IDLE; requesters withdrawing req_valid before ready is legal.
//  rsp_rdata/rsp_err hold until next completion; rsp_valid strictly 1-cycle pulse.
//  paddr/pwdata retain last value in IDLE (not cleared) to avoid glitching.
// TESTING
//  1 reset then req0 write addr 8'h00 data 8'h35, pready=1 -> psel rise T+1, penable T+2,
//    rsp_valid=4'b0001 T+3, rsp_err=0; timer reg 0x00 reads back 8'h35.
//  2 req1 read addr 8'h04 with prdata=8'hA5 -> rsp_valid=4'b0010, rsp_rdata=8'hA5.
//  3 all 4 req_valid held continuously for 8 grants -> grant order 0,1,2,3,0,1,2,3; psel=0 for
//    exactly 1 cycle between each transfer; APB write/stable-address assertions never fire.
//  4 pready held 0 -> after 16 ACCESS cycles abort, rsp_err=1, rsp_rdata=0; next req proceeds.
//  5 pready low 3 cycles then high -> rsp_valid on cycle after pready, rsp_err=0, addr stable.
//  6 presetn=0 during ACCESS -> next edge psel=penable=0, no rsp_valid, ptr=0; req0 wins after.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Shares one APB master port among NUM_REQ requesters. A round-robin
//   pointer picks a winner in IDLE, the request is latched and driven as a
//   standard SETUP/ACCESS transfer, and the completion (read data, timeout
//   status) is returned as a one-cycle strobe to the original requester.
//   Every transfer ends back in IDLE, so psel is low for at least one cycle
//   between transfers.
// Ports
//   pclk, presetn        clock, synchronous active-low reset
//   req_valid/write      per-requester request and direction (1 = write)
//   req_addr/req_wdata   flattened per-requester address / write data
//   req_ready            one-hot accept strobe, combinational, IDLE only
//   rsp_valid            one-hot completion strobe (1 cycle)
//   rsp_rdata, rsp_err   completion data / timeout flag, held until next
//   psel..pwdata         APB master outputs
//   prdata, pready       APB slave inputs
module apb_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [AW-1:0]         paddr,
    output logic [DW-1:0]         pwdata,
    input  logic [DW-1:0]         prdata,
    input  logic                  pready
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]         state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     id;
    logic [CW-1:0]      cnt;

    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] id_onehot;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     ptr_nxt;
    logic               any_req;
    logic               win_write;
    logic [AW-1:0]      win_addr;
    logic [DW-1:0]      win_wdata;

    // Round-robin pick: requests at or above the pointer take priority;
    // if none, wrap and take the lowest pending request overall.
    always_comb begin
        hi_req  = '0;
        winner  = '0;
        any_req = |req_valid;
        for (int i = 0; i < NUM_REQ; i++)
            hi_req[i] = req_valid[i] && (i >= int'(ptr));
        if (|hi_req) begin
            for (int i = NUM_REQ - 1; i >= 0; i--)
                if (hi_req[i]) winner = IDW'(i);
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--)
                if (req_valid[i]) winner = IDW'(i);
        end
        ptr_nxt = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
    end

    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        req_ready = '0;
        id_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == winner) begin
                win_write = req_write[i];
                win_addr  = req_addr[i*AW +: AW];
                win_wdata = req_wdata[i*DW +: DW];
                req_ready[i] = (state == IDLE) && any_req;
            end
            id_onehot[i] = (IDW'(i) == id);
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            cnt       <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        pwrite  <= win_write;
                        paddr   <= win_addr;
                        pwdata  <= win_wdata;
                        id      <= winner;
                        ptr     <= ptr_nxt;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= id_onehot;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end else if (TIMEOUT_CYC != 0 && cnt == CNT_MAX) begin
                        // Slave never answered: release the bus and report an error.
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= id_onehot;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
//   Directed bench for apb_req_arbiter with a small APB register-file slave
//   model and a bus protocol monitor.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            pclk = 1'b0;
    logic            presetn;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, pwdata, prdata;
    logic [AW-1:0]   paddr;
    logic            rsp_err, psel, penable, pwrite, slave_ready;

    int checks = 0;
    int errors = 0;
    int prot_viol = 0;

    logic [7:0] mem [0:255];

    always #5 pclk = ~pclk;

    apb_req_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(slave_ready)
    );

    // Register-file slave
    assign prdata = mem[paddr];
    always @(posedge pclk)
        if (psel && penable && slave_ready && pwrite) mem[paddr] <= pwdata;

    // Protocol monitor: SETUP before ACCESS, stable controls, no ACCESS->SETUP
    logic       m_psel = 1'b0, m_pen = 1'b0, m_wr = 1'b0;
    logic [7:0] m_addr = '0, m_wdata = '0;
    always @(negedge pclk) begin
        if (presetn) begin
            if (penable && !psel) prot_viol++;
            if (psel && penable && !m_psel) prot_viol++;
            if (psel && penable && m_psel &&
                (paddr !== m_addr || pwrite !== m_wr || pwdata !== m_wdata)) prot_viol++;
            if (psel && !penable && m_psel && m_pen) prot_viol++;
        end
        m_psel = psel; m_pen = penable; m_wr = pwrite; m_addr = paddr; m_wdata = pwdata;
    end

    task automatic tick;
        @(posedge pclk); #1;
    endtask

    // Raise one request and hold it until accepted; returns in the SETUP cycle.
    task automatic issue(input int id, input logic w, input logic [7:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        req_valid[id] = 1'b1;
        req_write[id] = w;
        req_addr[id*AW +: AW] = a;
        req_wdata[id*DW +: DW] = d;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready[id]) begin got = 1'b1; break; end
            @(posedge pclk); #1;
        end
        if (got) begin
            @(posedge pclk); #1;
        end else begin
            checks++; errors++;
            $display("FAIL issue_timeout req%0d got req_ready=%b want grant", id, req_ready);
        end
        req_valid[id] = 1'b0;
    endtask

    // Wait for a completion strobe; n = cycles waited from the call.
    task automatic wait_rsp(output logic [3:0] v, output logic [7:0] rd, output logic e, output int n);
        v = '0; rd = '0; e = 1'b0; n = 0;
        for (int k = 0; k < 60; k++) begin
            if (rsp_valid !== '0) begin
                v = rsp_valid; rd = rsp_rdata; e = rsp_err;
                return;
            end
            tick; n++;
        end
        checks++; errors++;
        $display("FAIL rsp_timeout got rsp_valid=%b want a completion", rsp_valid);
    endtask

    task automatic test_reset;
        presetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        slave_ready = 1'b1;
        tick; tick;
        checks++;
        if ({psel, penable, pwrite} !== 3'b000)
            begin errors++; $display("FAIL reset_ctrl got %b want 000", {psel, penable, pwrite}); end
        checks++;
        if (paddr !== 8'h00 || pwdata !== 8'h00)
            begin errors++; $display("FAIL reset_bus got %h/%h want 00/00", paddr, pwdata); end
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0)
            begin errors++; $display("FAIL reset_rsp got %b/%h/%b want 0000/00/0", rsp_valid, rsp_rdata, rsp_err); end
        checks++;
        if (req_ready !== 4'b0000)
            begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        presetn = 1'b1;
        tick;
    endtask

    task automatic test_single_write;
        logic [3:0] v; logic [7:0] rd; logic e; int n;
        req_valid = 4'b0001; req_write[0] = 1'b1; req_addr[7:0] = 8'h00; req_wdata[7:0] = 8'h35;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || psel !== 1'b0)
            begin errors++; $display("FAIL wr_accept got ready=%b psel=%b want 0001/0", req_ready, psel); end
        tick; req_valid = '0;
        checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== 8'h00 || pwdata !== 8'h35)
            begin errors++; $display("FAIL wr_setup got %b %h %h want 101 00 35", {psel, penable, pwrite}, paddr, pwdata); end
        tick;
        checks++;
        if ({psel, penable} !== 2'b11 || rsp_valid !== 4'b0000)
            begin errors++; $display("FAIL wr_access got %b rsp=%b want 11 0000", {psel, penable}, rsp_valid); end
        tick;
        checks++;
        if (psel !== 1'b0 || rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00)
            begin errors++; $display("FAIL wr_rsp got psel=%b rsp=%b err=%b rd=%h want 0 0001 0 00", psel, rsp_valid, rsp_err, rsp_rdata); end
        tick;
        checks++;
        if (rsp_valid !== 4'b0000)
            begin errors++; $display("FAIL wr_pulse got %b want 0000", rsp_valid); end
        issue(0, 1'b0, 8'h00, 8'h00);
        wait_rsp(v, rd, e, n);
        checks++;
        if (v !== 4'b0001 || rd !== 8'h35 || e !== 1'b0)
            begin errors++; $display("FAIL wr_readback got %b/%h/%b want 0001/35/0", v, rd, e); end
        tick;
    endtask

    task automatic test_read;
        logic [3:0] v; logic [7:0] rd; logic e; int n;
        issue(1, 1'b0, 8'h04, 8'h00);
        wait_rsp(v, rd, e, n);
        checks++;
        if (v !== 4'b0010 || rd !== 8'hA5 || e !== 1'b0 || n != 2)
            begin errors++; $display("FAIL rd_basic got %b/%h/%b lat=%0d want 0010/a5/0 lat=2", v, rd, e, n); end
        tick;
    endtask

    task automatic test_wait_states;
        slave_ready = 1'b0;
        issue(0, 1'b0, 8'h04, 8'h00);
        tick; tick; tick;
        checks++;
        if ({psel, penable} !== 2'b11 || rsp_valid !== 4'b0000 || paddr !== 8'h04)
            begin errors++; $display("FAIL ws_hold got %b rsp=%b addr=%h want 11 0000 04", {psel, penable}, rsp_valid, paddr); end
        slave_ready = 1'b1;
        tick;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0 || psel !== 1'b0)
            begin errors++; $display("FAIL ws_rsp got %b/%h/%b psel=%b want 0001/a5/0 0", rsp_valid, rsp_rdata, rsp_err, psel); end
        tick;
        checks++;
        if (rsp_valid !== 4'b0000)
            begin errors++; $display("FAIL ws_pulse got %b want 0000", rsp_valid); end
    endtask

    task automatic test_timeout;
        logic [3:0] v; logic [7:0] rd; logic e; int n;
        issue(3, 1'b0, 8'h04, 8'h00);
        wait_rsp(v, rd, e, n);
        tick;
        slave_ready = 1'b0;
        issue(2, 1'b0, 8'h10, 8'h00);
        wait_rsp(v, rd, e, n);
        checks++;
        if (v !== 4'b0100 || e !== 1'b1 || rd !== 8'h00 || n != 17)
            begin errors++; $display("FAIL to_abort got %b/%h/%b lat=%0d want 0100/00/1 lat=17", v, rd, e, n); end
        tick;
        slave_ready = 1'b1;
        issue(1, 1'b1, 8'h20, 8'h5A);
        wait_rsp(v, rd, e, n);
        checks++;
        if (v !== 4'b0010 || e !== 1'b0 || n != 2 || mem[8'h20] !== 8'h5A)
            begin errors++; $display("FAIL to_next got %b/%b lat=%0d mem=%h want 0010/0 lat=2 5a", v, e, n, mem[8'h20]); end
        tick;
    endtask

    task automatic test_round_robin;
        int grants, gap;
        logic prev_psel, seen;
        logic [3:0] expv, v;
        logic [7:0] rd; logic e; int n;
        presetn = 1'b0; tick; presetn = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = 8'h40 + 8'(i);
            req_wdata[i*DW +: DW] = 8'h10 + 8'(i);
        end
        req_write = 4'hF; slave_ready = 1'b1;
        grants = 0; gap = 0; prev_psel = 1'b0; seen = 1'b0;
        req_valid = 4'hF; #1;
        for (int c = 0; c < 60 && grants < 8; c++) begin
            if (psel && !prev_psel && seen) begin
                checks++;
                if (gap != 1) begin errors++; $display("FAIL rr_gap got %0d want 1", gap); end
            end
            if (psel) begin seen = 1'b1; gap = 0; end else gap++;
            prev_psel = psel;
            if (req_ready !== 4'b0000) begin
                expv = 4'b0001 << (grants % 4);
                checks++;
                if (req_ready !== expv)
                    begin errors++; $display("FAIL rr_grant%0d got %b want %b", grants, req_ready, expv); end
                grants++;
            end
            tick;
        end
        req_valid = '0;
        checks++;
        if (grants != 8) begin errors++; $display("FAIL rr_count got %0d want 8", grants); end
        wait_rsp(v, rd, e, n);
        checks++;
        if (v !== 4'b1000 || mem[8'h43] !== 8'h13)
            begin errors++; $display("FAIL rr_last got %b mem=%h want 1000 13", v, mem[8'h43]); end
        tick;
    endtask

    task automatic test_reset_mid_access;
        logic [3:0] v; logic [7:0] rd; logic e; int n;
        slave_ready = 1'b0;
        issue(2, 1'b0, 8'h10, 8'h00);
        tick;
        checks++;
        if ({psel, penable} !== 2'b11)
            begin errors++; $display("FAIL rst_pre got %b want 11", {psel, penable}); end
        presetn = 1'b0;
        tick;
        checks++;
        if ({psel, penable} !== 2'b00 || rsp_valid !== 4'b0000)
            begin errors++; $display("FAIL rst_drop got %b rsp=%b want 00 0000", {psel, penable}, rsp_valid); end
        presetn = 1'b1; slave_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++;
            if (rsp_valid !== 4'b0000 || psel !== 1'b0)
                begin errors++; $display("FAIL rst_quiet got rsp=%b psel=%b want 0000 0", rsp_valid, psel); end
        end
        req_write = 4'b0000;
        req_addr[7:0] = 8'h04; req_addr[31:24] = 8'h10;
        req_valid = 4'b1001; #1;
        checks++;
        if (req_ready !== 4'b0001)
            begin errors++; $display("FAIL rst_ptr got %b want 0001", req_ready); end
        tick; req_valid = '0;
        wait_rsp(v, rd, e, n);
        checks++;
        if (v !== 4'b0001 || rd !== 8'hA5 || e !== 1'b0)
            begin errors++; $display("FAIL rst_after got %b/%h/%b want 0001/a5/0", v, rd, e); end
        tick;
    endtask

    task automatic test_protocol;
        checks++;
        if (prot_viol != 0)
            begin errors++; $display("FAIL apb_protocol got %0d violations want 0", prot_viol); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h04] = 8'hA5;
        test_reset;
        test_single_write;
        test_read;
        test_wait_states;
        test_timeout;
        test_round_robin;
        test_reset_mid_access;
        test_protocol;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
